// File: rtl/debounce_sync.sv
// debounce_sync
//   Turns a raw asynchronous single-bit input (push-button or switch) into a
//   clean level synchronous to clk. The signal passes through a 2-flop
//   synchronizer and then a counter-qualified debounce FSM. A new level must be
//   seen on STABLE_CYCLES consecutive synchronized samples before dout follows
//   it. Single-cycle rise/fall pulses mark each accepted edge.
//
// Ports
//   clk       in   system clock, rising-edge active
//   rst       in   synchronous, active-high reset (dominates everything)
//   din_async in   raw asynchronous input
//   dout      out  debounced, synchronized level (registered)
//   rise      out  one-cycle pulse in the first cycle dout shows 1
//   fall      out  one-cycle pulse in the first cycle dout shows 0
//   busy      out  high while a candidate transition is being qualified
//
// Parameters
//   STABLE_CYCLES  consecutive samples required to accept a change (2 .. 2**CNT_W-1)
//   CNT_W          width of the qualification counter
module debounce_sync #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s1;
  logic s2;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             dout_next;
  logic             rise_next;
  logic             fall_next;

  // ---- stage 0/1: two-flop synchronizer; only s2 is used downstream ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din_async;
      s2 <= s1;
    end
  end

  // ---- stage 2: debounce FSM state, counter and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      dout  <= dout_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Next-state logic. The counter holds the number of consecutive samples of
  // the candidate level seen so far; it is loaded with 1 on entry to a
  // qualifying state and tops out at STABLE_CYCLES-1, so it never wraps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dout_next  = dout;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state)
      LOW: begin
        if (s2) begin
          state_next = QUAL_HIGH;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      QUAL_HIGH: begin
        if (!s2) begin
          // excursion too short: back to LOW silently
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          dout_next  = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_next = QUAL_LOW;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      QUAL_LOW: begin
        if (s2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          dout_next  = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
        dout_next  = 1'b0;
      end
    endcase
  end

  // Moore decode of the state register
  assign busy = (state == QUAL_HIGH) || (state == QUAL_LOW);

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous single-bit input (push-button or switch) into a clean, clock-synchronous level for the downstream D flip-flop stage.
- Signal path:
  - 2-flop synchronizer.
  - Counter-qualified debounce FSM.
  - Registered level output (dout), wired to the flip-flop d input.
  - One-cycle rise/fall pulses, usable as enables downstream.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized samples of a new value required before dout changes. Legal range 2 .. 2**CNT_W-1.
- CNT_W, 8: width of the qualification counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- din_async  input  1  raw asynchronous input.
- dout  output  1  debounced, synchronized level.
- rise  output  1  one-cycle pulse on dout 0->1.
- fall  output  1  one-cycle pulse on dout 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the clk rising edge. Reset dominates all other activity.
- Reset values: sync flops s1=0, s2=0; state=LOW; cnt=0; dout=0; rise=0; fall=0; busy=0.
- Synchronizer: s1<=din_async, s2<=s1. The FSM sees only s2, never din_async or s1.
- FSM states: LOW, QUAL_HIGH, HIGH, QUAL_LOW.
  - LOW:
    - s2=1 -> QUAL_HIGH, cnt<=1.
    - else stay, cnt<=0.
  - QUAL_HIGH:
    - s2=0 -> LOW, cnt<=0. Glitch rejected, no pulse.
    - s2=1 and cnt==STABLE_CYCLES-1 -> HIGH, dout<=1, rise<=1, cnt<=0.
    - s2=1 otherwise -> cnt<=cnt+1.
  - HIGH:
    - s2=0 -> QUAL_LOW, cnt<=1.
    - else stay.
  - QUAL_LOW: mirror of QUAL_HIGH.
    - s2=1 -> HIGH, no pulse.
    - s2=0 and cnt==STABLE_CYCLES-1 -> LOW, dout<=0, fall<=1.
    - s2=0 otherwise -> cnt<=cnt+1.
- Outputs:
  - rise and fall are registered and default to 0 every cycle. Each is high for exactly the first cycle in which dout shows its new value.
  - rise and fall are never high together.
  - busy is a Moore decode of the state register: 1 in QUAL_HIGH or QUAL_LOW.
- Latency: din_async stable from edge k (the first edge capturing the new value into s1):
  - s2 changes at edge k+1.
  - dout and the pulse change at edge k+STABLE_CYCLES+1. This is edge k+5 at the default.
- Glitch rule: an input excursion shorter than STABLE_CYCLES synchronized samples never changes dout and produces no pulse.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around. CNT_W must hold STABLE_CYCLES.
- Reset mid-qualification: state returns to LOW and dout=0 at that edge, with no pulse. If din_async is held high, a full requalification follows, and dout rises STABLE_CYCLES+2 edges after the last edge with rst=1.
- Reset while HIGH: dout drops to 0 with no fall pulse.

Test Plan:
Bench setup: STABLE_CYCLES=4, 10 ns clk period.
1. din_async=1 during rst=1 for 2 edges:
   - During reset: dout=0, rise=0, busy=0.
   - After release: dout=1 exactly 6 edges after the last reset edge, with rise=1 for one cycle.
2. Clean 0->1 step captured at edge k:
   - busy=1 after edges k+2 .. k+4.
   - dout=1 and rise=1 after edge k+5.
   - rise=0 after edge k+6.
3. From HIGH, clean 1->0 step:
   - fall pulses one cycle and dout=0 at k+5.
   - rise stays 0 throughout.
4. 3-cycle high glitch from LOW:
   - busy rises then returns to 0.
   - dout stays 0; rise and fall never assert.
5. rst=1 asserted for one edge while in QUAL_HIGH with cnt=2:
   - Next cycle: busy=0, dout=0, no rise.
   - Requalification then completes per scenario 1 timing.
6. din_async toggling every cycle for 20 cycles:
   - dout unchanged and no pulses.
   - Then hold at 1: dout rises at k+5.
